// File: rtl/sr_ctrl_pkg.sv
// Shared FSM encoding and operation codes for the SR latch controller.
// No logic of its own; imported by the controller.
package sr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    CHECK = 3'd2,
    FIN   = 3'd3,
    GAP   = 3'd4
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit. Latency 2 cycles.
// No backpressure; samples every cycle.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Round-robin owner of one NOR SR latch: timed S/R pulses, Q/Qbar-confirmed completion.
// Latency 3 cycles (skip) or 1+PULSE_W+CHECK+1 after sample; requesters hold req until done.
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] grant,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic             S,
  output logic             R,
  input  logic             Q,
  input  logic             Qbar
);

  localparam int PW   = $clog2(N_REQ);
  localparam int CMAX = (PULSE_W > GAP_W) ? ((PULSE_W > TIMEOUT) ? PULSE_W : TIMEOUT)
                                          : ((GAP_W > TIMEOUT) ? GAP_W : TIMEOUT);
  localparam int CW   = $clog2(CMAX + 1);

  state_t        state;
  logic          sel;
  logic [PW-1:0] idx;
  logic [PW-1:0] ptr;
  logic [PW-1:0] pick;
  logic          tgt;
  logic [CW-1:0] cnt;
  logic          q_s;
  logic          qb_s;
  logic          fb_ok;

  // First active requester at or after p, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] res;
    logic          found;
    int            j;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(p) + i) % N_REQ;
      if (!found && r[j]) begin
        res   = PW'(j);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign pick  = rr_pick(req, ptr);
  assign fb_ok = (q_s == tgt) && (qb_s == ~tgt);

  sync_2ff u_q_sync (
    .clk (clk),
    .rst (rst),
    .d   (Q),
    .q   (q_s)
  );

  sync_2ff u_qb_sync (
    .clk (clk),
    .rst (rst),
    .d   (Qbar),
    .q   (qb_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= 1'b0;
      idx   <= '0;
      tgt   <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
      grant <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
      S     <= 1'b0;
      R     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          // Owner and target are frozen one cycle before the skip/pulse decision.
          if (!sel) begin
            if (|req) begin
              idx   <= pick;
              tgt   <= op[pick];
              grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
              sel   <= 1'b1;
            end
          end else begin
            sel  <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
            if (fb_ok) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= PULSE;
              S     <= (tgt == OP_SET);
              R     <= (tgt == OP_CLR);
            end
          end
        end
        PULSE: begin
          if (cnt == CW'(PULSE_W - 1)) begin
            state <= CHECK;
            cnt   <= '0;
            S     <= 1'b0;
            R     <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          if (fb_ok) begin
            state <= FIN;
            cnt   <= '0;
            done  <= 1'b1;
          end else if ((q_s == qb_s) || (cnt == CW'(TIMEOUT - 1))) begin
            state <= FIN;
            cnt   <= '0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          state <= GAP;
          cnt   <= '0;
          grant <= '0;
          ptr   <= (idx == PW'(N_REQ - 1)) ? '0 : idx + 1'b1;
        end
        GAP: begin
          if (cnt == CW'(GAP_W - 1)) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          grant <= '0;
          busy  <= 1'b0;
          S     <= 1'b0;
          R     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl with a behavioural SR latch whose outputs can be pinned.
// Vector table, hand-written corner sequences and a randomized run against a transaction model.
module tb_sr_latch_ctrl;

  localparam int N_REQ   = 4;
  localparam int PULSE_W = 2;
  localparam int GAP_W   = 1;
  localparam int TIMEOUT = 15;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic             err;
  logic             busy;
  logic             S;
  logic             R;
  logic             Q;
  logic             Qbar;

  // 0: real latch, 1: pinned Q=0/Qbar=1, 2: pinned Q=Qbar=0
  logic [1:0] mode;
  logic       lq;
  logic       pre_clr;

  int n_test;
  int n_fail;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] opv;
    logic [1:0] md;
    int         idx;
    int         sc;
    int         rc;
    logic       e;
    int         lat;
    logic       q;
  } vec_t;

  vec_t tv[8];

  sr_latch_ctrl #(
    .N_REQ   (N_REQ),
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .grant (grant),
    .done  (done),
    .err   (err),
    .busy  (busy),
    .S     (S),
    .R     (R),
    .Q     (Q),
    .Qbar  (Qbar)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(S or R or pre_clr) begin
    if (pre_clr) lq = 1'b0;
    else if (S && !R) lq = 1'b1;
    else if (R && !S) lq = 1'b0;
  end

  assign Q    = (mode == 2'd0) ? lq : 1'b0;
  assign Qbar = (mode == 2'd0) ? ~lq : (mode == 2'd1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_test++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every cycle: never S and R together; done only with a single grant bit.
  task automatic tick();
    @(negedge clk);
    n_test++;
    if (S && R) begin
      n_fail++;
      $display("FAIL s_r_exclusive: S=%0b R=%0b, at most one may be high", S, R);
    end
    if (done) begin
      n_test++;
      if (!$onehot(grant)) begin
        n_fail++;
        $display("FAIL done_grant_onehot: grant=%b with done, need exactly one bit", grant);
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    op      = '0;
    pre_clr = 1'b1;
    tick();
    tick();
    chk("reset_outputs", 32'({grant, done, err, busy, S, R}), 32'd0);
    pre_clr = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic run_txn(input string nm, input logic [3:0] rq, input logic [3:0] opv,
                         input logic [1:0] md, input int eidx, input int esc, input int erc,
                         input logic eerr, input int elat, input logic eq);
    int   k;
    int   sc;
    int   rc;
    int   lat;
    logic got;
    mode = md;
    repeat (3) tick();
    req = rq;
    op  = opv;
    got = 1'b0;
    for (k = 0; k < 8 && !got; k++) begin
      tick();
      if (grant != '0) got = 1'b1;
    end
    chk({nm, "_grant"}, 32'(grant), 32'd1 << eidx);
    if (!got) begin
      req = '0;
      return;
    end
    // Dropped req and flipped op must not disturb the running operation.
    req = '0;
    op  = ~opv;
    sc  = S ? 1 : 0;
    rc  = R ? 1 : 0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      sc = sc + (S ? 1 : 0);
      rc = rc + (R ? 1 : 0);
      if (done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_latency"}, 32'(lat), 32'(elat));
      chk({nm, "_s_cycles"}, 32'(sc), 32'(esc));
      chk({nm, "_r_cycles"}, 32'(rc), 32'(erc));
      chk({nm, "_err"}, 32'(err), 32'(eerr));
      chk({nm, "_grant_at_done"}, 32'(grant), 32'd1 << eidx);
      chk({nm, "_q"}, 32'(Q), 32'(eq));
    end
    k = 0;
    while ((busy || grant != '0) && k < 10) begin
      tick();
      k++;
    end
    chk({nm, "_back_to_idle"}, 32'(busy || grant != '0), 32'd0);
  endtask

  int         m_ptr;
  logic       m_q;
  logic [3:0] r_rq;
  logic [3:0] r_op;
  logic [1:0] r_md;
  int         r_idx;
  int         r_sc;
  int         r_rc;
  int         r_lat;
  int         r_nchk;
  logic       r_e;
  logic       r_tgt;
  logic       r_qv;
  logic       r_qbv;
  int         z;
  logic       sr_seen;
  logic       got;

  initial begin
    n_test  = 0;
    n_fail  = 0;
    mode    = 2'd0;
    pre_clr = 1'b1;
    rst     = 1'b1;
    req     = '0;
    op      = '0;

    //          req      op       mode  idx sc rc err  lat q
    tv[0] = '{4'b0001, 4'b0001, 2'd0, 0, 2, 0, 1'b0, 4,  1'b1};
    tv[1] = '{4'b0100, 4'b0100, 2'd0, 2, 0, 0, 1'b0, 1,  1'b1};
    tv[2] = '{4'b0011, 4'b0000, 2'd0, 0, 0, 2, 1'b0, 4,  1'b0};
    tv[3] = '{4'b1010, 4'b1000, 2'd0, 1, 0, 0, 1'b0, 1,  1'b0};
    tv[4] = '{4'b1010, 4'b1000, 2'd0, 3, 2, 0, 1'b0, 4,  1'b1};
    tv[5] = '{4'b0001, 4'b0001, 2'd1, 0, 2, 0, 1'b1, 18, 1'b0};
    tv[6] = '{4'b0100, 4'b0000, 2'd2, 2, 0, 2, 1'b1, 4,  1'b0};
    tv[7] = '{4'b1111, 4'b0101, 2'd0, 3, 0, 0, 1'b0, 1,  1'b0};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), tv[i].rq, tv[i].opv, tv[i].md, tv[i].idx,
              tv[i].sc, tv[i].rc, tv[i].e, tv[i].lat, tv[i].q);
    end

    // Round-robin with all requesters held high.
    do_reset();
    mode = 2'd0;
    repeat (3) tick();
    req = 4'hF;
    op  = 4'h5;
    for (int k = 0; k < 5; k++) begin
      z       = 0;
      sr_seen = 1'b0;
      got     = 1'b0;
      for (int w = 0; w < 12 && !got; w++) begin
        tick();
        if (grant != '0) got = 1'b1;
        else begin
          z++;
          if (S || R) sr_seen = 1'b1;
        end
      end
      chk($sformatf("rr_grant%0d", k), 32'(grant), 32'd1 << (k % N_REQ));
      if (k > 0) begin
        chk($sformatf("rr_gap_len%0d", k), 32'(z), 32'(GAP_W + 1));
        chk($sformatf("rr_gap_sr%0d", k), 32'(sr_seen), 32'd0);
      end
      got = 1'b0;
      for (int w = 0; w < 40 && !got; w++) begin
        tick();
        if (done) got = 1'b1;
      end
      chk($sformatf("rr_done%0d", k), 32'(got), 32'd1);
    end
    req = '0;
    repeat (4) tick();

    // Reset in the middle of an S pulse; pointer must restart at requester 0.
    do_reset();
    run_txn("mp_pre", 4'b0100, 4'b0100, 2'd0, 2, 2, 0, 1'b0, 4, 1'b1);
    pre_clr = 1'b1;
    tick();
    pre_clr = 1'b0;
    repeat (3) tick();
    req = 4'b1000;
    op  = 4'b1000;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      tick();
      if (S) got = 1'b1;
    end
    chk("mp_s_seen", 32'(got), 32'd1);
    rst = 1'b1;
    req = '0;
    tick();
    chk("mp_rst_outputs", 32'({grant, done, err, busy, S, R}), 32'd0);
    rst = 1'b0;
    run_txn("mp_after", 4'b1010, 4'b0000, 2'd0, 1, 0, 2, 1'b0, 4, 1'b0);

    // Randomized transactions against the transaction-level model.
    do_reset();
    m_ptr = 0;
    m_q   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      r_rq = 4'($urandom_range(1, 15));
      r_op = 4'($urandom_range(0, 15));
      r_md = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      r_idx = -1;
      for (int i = 0; i < N_REQ; i++) begin
        if (r_idx < 0 && r_rq[(m_ptr + i) % N_REQ]) r_idx = (m_ptr + i) % N_REQ;
      end
      r_tgt = r_op[r_idx];
      r_qv  = (r_md == 2'd0) ? m_q : 1'b0;
      r_qbv = (r_md == 2'd0) ? ~m_q : (r_md == 2'd1);
      if (r_qv == r_tgt && r_qbv == ~r_tgt) begin
        r_sc  = 0;
        r_rc  = 0;
        r_e   = 1'b0;
        r_lat = 1;
      end else begin
        r_sc = r_tgt ? PULSE_W : 0;
        r_rc = r_tgt ? 0 : PULSE_W;
        m_q  = r_tgt;
        // Feedback becomes visible two cycles after the pulse starts.
        if (r_md == 2'd1) r_nchk = TIMEOUT;
        else if (r_md == 2'd2) r_nchk = 1;
        else r_nchk = (3 - PULSE_W > 1) ? 3 - PULSE_W : 1;
        r_e   = (r_md != 2'd0);
        r_lat = 1 + PULSE_W + r_nchk;
      end
      m_ptr = (r_idx + 1) % N_REQ;
      run_txn($sformatf("rnd%0d", n), r_rq, r_op, r_md, r_idx, r_sc, r_rc, r_e, r_lat,
              (r_md == 2'd0) ? m_q : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
Name: sr_latch_ctrl

Overview:
- Synchronous controller that shares one cross-coupled NOR SR latch between N_REQ requesters.
- Each requester asks to set or clear the latch. The controller arbitrates round-robin and drives timed S/R pulses.
- S and R are never asserted together, so the forbidden NOR state is impossible.
- Completion is confirmed from the latch's Q/Qbar feedback, with a timeout. Sits between control logic and the gate-level latch instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- PULSE_W, 2, cycles S or R is held high per operation (>=1).
- GAP_W, 1, idle cycles with S=R=0 after each operation (>=1).
- TIMEOUT, 15, max CHECK cycles waiting for feedback before error (>=1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held high until its done.
- op  in  N_REQ  per-requester operation: 1=set (Q->1), 0=clear (Q->0); sampled at grant.
- grant  out  N_REQ  one-hot; owner of the current operation.
- done  out  1  one-cycle pulse: operation finished (ok or error).
- err  out  1  one-cycle pulse with done: timeout, or Q==Qbar seen in CHECK.
- busy  out  1  high in any state other than IDLE.
- S  out  1  latch set drive.
- R  out  1  latch reset drive.
- Q  in  1  latch output, asynchronous.
- Qbar  in  1  latch complementary output, asynchronous.

Behaviour:
- Reset (any state, including mid-pulse): next edge S=R=0, grant=0, done=err=busy=0, state=IDLE, rr pointer=0, counters=0, synchronizer flops=0.
- Q/Qbar pass through 2-flop synchronizers (q_s, qb_s) before use. Feedback latency is 2 cycles.

FSM states:
- IDLE:
  - If no req bit is high, stay.
  - Otherwise pick the first set req bit at or after ptr, wrapping modulo N_REQ. Latch idx and tgt=op[idx], and assert grant[idx] next cycle.
  - Go to PULSE, except: if q_s==tgt and qb_s==~tgt, go to FIN (skip; no pulse issued).
- PULSE: S=tgt, R=~tgt for exactly PULSE_W cycles, then go to CHECK.
- CHECK: S=R=0.
  - Success: q_s==tgt and qb_s==~tgt -> FIN ok.
  - Error: q_s==qb_s -> FIN err.
  - Timeout: cnt reaches TIMEOUT -> FIN err.
- FIN (1 cycle): done=1, err as determined, grant still asserted, ptr<=idx+1 mod N_REQ. Go to GAP.
- GAP: grant=0, S=R=0 for GAP_W cycles, then IDLE.

Timing and rules:
- Minimum latency, req rise to done, latch already in target: 3 cycles (IDLE sample, grant, FIN).
- Normal op: 1 + PULSE_W + (>=1 CHECK) + 1 cycles.
- S&R==1 is illegal in every cycle. outputs S and R are registered.
- A req deasserted after grant does not abort the operation; done still pulses. A new req is only considered in IDLE.
- An op change after grant is ignored; tgt is frozen.
- Counter width $clog2(max(PULSE_W,GAP_W,TIMEOUT)+1). The counter is cleared on every state entry.

Decomposition:
- Shared package sr_ctrl_pkg: state encoding localparams (IDLE, PULSE, CHECK, FIN, GAP), OP_SET=1, OP_CLR=0.
- One natural sub-module: sync_2ff (1-bit, reset to 0), instantiated twice for Q and Qbar.
- The round-robin picker stays inline as a function.

Test Plan:
- Closed loop with SR_latch_gate, latch pre-cleared. req=4'b0001, op=1 -> grant=0001 next cycle, S high 2 cycles, R never high, done (err=0) 3-5 cycles later, Q=1.
- Skip path: Q already 1, req[2]=1, op[2]=1 -> S and R stay 0, done 3 cycles after req, grant=0100 for 2 cycles.
- Round-robin: req=4'b1111 held, alternating op -> grants in order 0001,0010,0100,1000,0001. GAP_W cycles of S=R=0 between each.
- Timeout: Q/Qbar forced stuck at 0/1, set request -> after the PULSE, 15 CHECK cycles, then done=1 and err=1.
- Reset mid-PULSE (S=1): rst for 1 cycle -> next edge S=0, grant=0, busy=0. Next request is served starting from requester 0.
- Assertion across all tests: never S&R; done implies exactly one grant bit set.
